result_pairer: RTL and testbench

Downstream stage of the packet-sum pipeline. Captures the 32-bit sum result (`in1_*`) and the 64-bit sum+1 result (`in2_*`) of each packet, which arrive on separate valid strobes at different latencies. Pairs them in arrival order, tags each pair with a sequence number, and buffers the record for a valid/ready consumer. Sticky error flags report unmatched or dropped results.

---
 rtl/result_pairer.sv | 121 ++++++++++++
 tb/tb_result_pairer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_pairer.sv
// result_pairer: pairs 32-bit and 64-bit pipeline results in arrival order into seq-tagged records
//
// Ports:
//   clk           sole clock, rising edge
//   rst           asynchronous active-low reset
//   in1_data/_valid   32-bit result strobe (pushed into the pending FIFO)
//   in2_data/_valid   64-bit result strobe (pairs with oldest pending 32-bit result)
//   res_sum/_sum1/_seq/_valid, res_ready   FWFT valid/ready record output
//   pend_count    pending FIFO occupancy
//   err_orphan    sticky: 64-bit result with no 32-bit partner
//   err_overflow  sticky: pending or output FIFO overflow
//   drop_cnt      saturating count of dropped in1 entries and records
//   clr_err       synchronous clear of the error flags and drop_cnt
module result_pairer #(
   parameter int PEND_DEPTH = 4,
   parameter int OUT_DEPTH  = 4,
   parameter int SEQ_W      = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [31:0]                   in1_data,
   input  logic                          in1_valid,
   input  logic [63:0]                   in2_data,
   input  logic                          in2_valid,
   output logic [31:0]                   res_sum,
   output logic [63:0]                   res_sum1,
   output logic [SEQ_W-1:0]              res_seq,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic [$clog2(PEND_DEPTH):0]   pend_count,
   output logic                          err_orphan,
   output logic                          err_overflow,
   output logic [15:0]                   drop_cnt,
   input  logic                          clr_err
);
   localparam int PA = $clog2(PEND_DEPTH);
   localparam int PW = PA + 1;
   localparam int OA = $clog2(OUT_DEPTH);
   localparam int OW = OA + 1;
   localparam int RW = 96 + SEQ_W;

   logic [31:0]      pmem_q [PEND_DEPTH];
   logic [PA-1:0]    prd_q, pwr_q;
   logic [PW-1:0]    pcnt_q, pcnt_d;
   logic [RW-1:0]    omem_q [OUT_DEPTH];
   logic [OA-1:0]    ord_q, owr_q;
   logic [OW-1:0]    ocnt_q, ocnt_d;
   logic [SEQ_W-1:0] seq_q;
   logic             orphan_q, orphan_d, ovf_q, ovf_d;
   logic [15:0]      drop_q, drop_d;
   logic [16:0]      drop_sum;
   logic             p_empty, p_full, p_pop, p_push, p_drop, bypass, orphan, pair;
   logic             o_full, o_pop, o_push, o_drop;
   logic [31:0]      pair_sum;
   logic [RW-1:0]    head;

   always_comb begin
      p_empty  = pcnt_q == '0;
      p_full   = pcnt_q == PW'(PEND_DEPTH);
      p_pop    = in2_valid & ~p_empty;
      // with nothing pending, a coincident in1 is consumed directly and never stored
      bypass   = in2_valid & p_empty & in1_valid;
      orphan   = in2_valid & p_empty & ~in1_valid;
      p_push   = in1_valid & ~bypass & (~p_full | p_pop);
      p_drop   = in1_valid & ~bypass & p_full & ~p_pop;
      pair     = p_pop | bypass;
      pair_sum = p_pop ? pmem_q[prd_q] : in1_data;
      o_full   = ocnt_q == OW'(OUT_DEPTH);
      o_pop    = res_valid & res_ready;
      o_push   = pair & (~o_full | o_pop);
      o_drop   = pair & o_full & ~o_pop;
      pcnt_d   = pcnt_q + PW'(p_push) - PW'(p_pop);
      ocnt_d   = ocnt_q + OW'(o_push) - OW'(o_pop);
      drop_sum = {1'b0, drop_q} + 17'(p_drop) + 17'(o_drop);
      drop_d   = clr_err ? 16'd0 : drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      orphan_d = ~clr_err & (orphan_q | orphan);
      ovf_d    = ~clr_err & (ovf_q | p_drop | o_drop);
   end

   always_ff @(posedge clk) begin
      if (p_push) pmem_q[pwr_q] <= in1_data;
      if (o_push) omem_q[owr_q] <= {pair_sum, in2_data, seq_q};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prd_q    <= '0;
         pwr_q    <= '0;
         pcnt_q   <= '0;
         ord_q    <= '0;
         owr_q    <= '0;
         ocnt_q   <= '0;
         seq_q    <= '0;
         orphan_q <= 1'b0;
         ovf_q    <= 1'b0;
         drop_q   <= '0;
      end else begin
         prd_q    <= prd_q + PA'(p_pop);
         pwr_q    <= pwr_q + PA'(p_push);
         pcnt_q   <= pcnt_d;
         ord_q    <= ord_q + OA'(o_pop);
         owr_q    <= owr_q + OA'(o_push);
         ocnt_q   <= ocnt_d;
         // seq advances even when the record is dropped so the consumer sees the gap
         seq_q    <= seq_q + SEQ_W'(pair);
         orphan_q <= orphan_d;
         ovf_q    <= ovf_d;
         drop_q   <= drop_d;
      end
   end

   always_comb begin
      res_valid = ocnt_q != '0;
      head      = omem_q[ord_q];
      {res_sum, res_sum1, res_seq} = res_valid ? head : '0;
      pend_count   = pcnt_q;
      err_orphan   = orphan_q;
      err_overflow = ovf_q;
      drop_cnt     = drop_q;
   end
endmodule

// File: tb/tb_result_pairer.sv
// tb_result_pairer: scoreboard bench for result_pairer
module tb_result_pairer;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] in1_data = '0;
   logic        in1_valid = 1'b0;
   logic [63:0] in2_data = '0;
   logic        in2_valid = 1'b0;
   logic [31:0] res_sum;
   logic [63:0] res_sum1;
   logic [7:0]  res_seq;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [2:0]  pend_count;
   logic        err_orphan, err_overflow;
   logic [15:0] drop_cnt;
   logic        clr_err = 1'b0;

   logic [103:0] sb[$];
   logic [103:0] exp_rec;
   int n_run = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   result_pairer #(.PEND_DEPTH(4), .OUT_DEPTH(4), .SEQ_W(8)) dut (
      .clk(clk), .rst(rst),
      .in1_data(in1_data), .in1_valid(in1_valid),
      .in2_data(in2_data), .in2_valid(in2_valid),
      .res_sum(res_sum), .res_sum1(res_sum1), .res_seq(res_seq),
      .res_valid(res_valid), .res_ready(res_ready),
      .pend_count(pend_count), .err_orphan(err_orphan),
      .err_overflow(err_overflow), .drop_cnt(drop_cnt), .clr_err(clr_err)
   );

   // one clock; any record the consumer takes at this edge is scored against the queue
   task automatic cyc();
      @(negedge clk);
      if (rst && res_valid && res_ready) begin
         n_run++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_record got %h_%h_%h expected none", res_sum, res_sum1, res_seq);
         end else begin
            exp_rec = sb.pop_front();
            if ({res_sum, res_sum1, res_seq} !== exp_rec) begin
               n_fail++;
               $display("FAIL record got %h_%h_%h expected %h", res_sum, res_sum1, res_seq, exp_rec);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      in1_valid = 1'b0;
      in2_valid = 1'b0;
      clr_err = 1'b0;
      sb.delete();
      repeat (2) cyc();
      rst = 1'b1;
   endtask

   task automatic nominal_pair(input logic [31:0] s, input logic [63:0] s1);
      in1_data = s;
      in1_valid = 1'b1;
      cyc();
      in1_valid = 1'b0;
      in2_data = s1;
      in2_valid = 1'b1;
      cyc();
      in2_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() > 0; i++) cyc();
      n_run++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain got %0d outstanding expected 0", sb.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #2;
      n_run++;
      if ({res_valid, res_sum, res_sum1, res_seq} !== '0) begin
         n_fail++;
         $display("FAIL reset_out got %b %h %h %h expected zeros", res_valid, res_sum, res_sum1, res_seq);
      end
      n_run++;
      if ({pend_count, err_orphan, err_overflow, drop_cnt} !== '0) begin
         n_fail++;
         $display("FAIL reset_status got %0d %b %b %0d expected zeros", pend_count, err_orphan, err_overflow, drop_cnt);
      end
      do_reset();
   endtask

   task automatic test_nominal();
      do_reset();
      res_ready = 1'b1;
      repeat (8) cyc();
      n_run++;
      if (pend_count !== 3'd0) begin n_fail++; $display("FAIL nom_pend0 got %0d expected 0", pend_count); end
      in1_data = 32'd136;
      in1_valid = 1'b1;
      cyc();
      in1_valid = 1'b0;
      n_run++;
      if (pend_count !== 3'd1) begin n_fail++; $display("FAIL nom_pend1 got %0d expected 1", pend_count); end
      in2_data = 64'd137;
      in2_valid = 1'b1;
      sb.push_back({32'd136, 64'd137, 8'd0});
      cyc();
      in2_valid = 1'b0;
      n_run++;
      if (pend_count !== 3'd0) begin n_fail++; $display("FAIL nom_pend2 got %0d expected 0", pend_count); end
      n_run++;
      if (res_valid !== 1'b1) begin n_fail++; $display("FAIL nom_valid got %b expected 1", res_valid); end
      cyc();
      n_run++;
      if (res_valid !== 1'b0) begin n_fail++; $display("FAIL nom_valid_drop got %b expected 0", res_valid); end
      drain();
   endtask

   task automatic test_bypass();
      do_reset();
      res_ready = 1'b1;
      in1_data = 32'd5;
      in2_data = 64'd6;
      in1_valid = 1'b1;
      in2_valid = 1'b1;
      sb.push_back({32'd5, 64'd6, 8'd0});
      cyc();
      in1_valid = 1'b0;
      in2_valid = 1'b0;
      n_run++;
      if (pend_count !== 3'd0) begin n_fail++; $display("FAIL byp_pend got %0d expected 0", pend_count); end
      n_run++;
      if (res_valid !== 1'b1) begin n_fail++; $display("FAIL byp_valid got %b expected 1", res_valid); end
      drain();
   endtask

   task automatic test_orphan();
      do_reset();
      res_ready = 1'b1;
      in2_data = 64'hDEAD;
      in2_valid = 1'b1;
      cyc();
      in2_valid = 1'b0;
      n_run++;
      if (err_orphan !== 1'b1) begin n_fail++; $display("FAIL orphan_flag got %b expected 1", err_orphan); end
      n_run++;
      if (res_valid !== 1'b0) begin n_fail++; $display("FAIL orphan_norec got %b expected 0", res_valid); end
      sb.push_back({32'd20, 64'd21, 8'd0});
      nominal_pair(32'd20, 64'd21);
      drain();
   endtask

   task automatic test_backpressure();
      do_reset();
      res_ready = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         if (k <= 4) sb.push_back({32'(k), 64'(k + 1), 8'(k - 1)});
         nominal_pair(32'(k), 64'(k + 1));
      end
      n_run++;
      if (drop_cnt !== 16'd2) begin n_fail++; $display("FAIL bp_drop got %0d expected 2", drop_cnt); end
      n_run++;
      if (err_overflow !== 1'b1) begin n_fail++; $display("FAIL bp_ovf got %b expected 1", err_overflow); end
      n_run++;
      if (res_valid !== 1'b1 || res_seq !== 8'd0) begin
         n_fail++;
         $display("FAIL bp_head got %b seq %0d expected 1 seq 0", res_valid, res_seq);
      end
      res_ready = 1'b1;
      drain();
      sb.push_back({32'd7, 64'd8, 8'd6});
      nominal_pair(32'd7, 64'd8);
      drain();
   endtask

   task automatic test_pend_overflow();
      do_reset();
      res_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         in1_data = 32'(100 + k);
         in1_valid = 1'b1;
         cyc();
      end
      in1_valid = 1'b0;
      n_run++;
      if (pend_count !== 3'd4) begin n_fail++; $display("FAIL povf_pend got %0d expected 4", pend_count); end
      n_run++;
      if (drop_cnt !== 16'd1 || err_overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL povf_err got drop %0d ovf %b expected 1 1", drop_cnt, err_overflow);
      end
      clr_err = 1'b1;
      cyc();
      clr_err = 1'b0;
      n_run++;
      if ({err_orphan, err_overflow, drop_cnt} !== '0) begin
         n_fail++;
         $display("FAIL clr got %b %b %0d expected zeros", err_orphan, err_overflow, drop_cnt);
      end
      n_run++;
      if (pend_count !== 3'd4) begin n_fail++; $display("FAIL clr_pend got %0d expected 4", pend_count); end
      // the oldest held entry (100) pairs first
      sb.push_back({32'd100, 64'd55, 8'd0});
      in2_data = 64'd55;
      in2_valid = 1'b1;
      cyc();
      in2_valid = 1'b0;
      drain();
   endtask

   task automatic test_async_reset();
      do_reset();
      res_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in1_data = 32'(40 + k);
         in2_data = 64'(50 + k);
         in1_valid = 1'b1;
         in2_valid = 1'b1;
         cyc();
      end
      in1_valid = 1'b0;
      in2_valid = 1'b0;
      n_run++;
      if (res_valid !== 1'b1) begin n_fail++; $display("FAIL ar_buffered got %b expected 1", res_valid); end
      #2;
      rst = 1'b0;
      #1;
      n_run++;
      if (res_valid !== 1'b0 || res_sum !== 32'd0) begin
         n_fail++;
         $display("FAIL ar_immediate got %b %h expected 0 0", res_valid, res_sum);
      end
      repeat (2) cyc();
      rst = 1'b1;
      res_ready = 1'b1;
      sb.push_back({32'd77, 64'd78, 8'd0});
      nominal_pair(32'd77, 64'd78);
      drain();
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_bypass();
      test_orphan();
      test_backpressure();
      test_pend_overflow();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
